wb_commit_stage: RTL and testbench
==================================

Name: wb_commit_stage

Overview:
- Writeback/commit end of the MEM→WB pipeline interface: the consumer side of the MEM/WB latch.
- Holds one instruction per cycle with a valid/allowin handshake.
- Extracts and extends load data, selects the final result, and drives the register-file write port.
- Commits exceptions and ERTN, then runs a flush FSM that discards younger instructions arriving from MEM.

Parameters:
- FLUSH_CYCLES, 2, number of cycles after an exception/ERTN commit during which incoming MEM instructions are discarded (1..15).
- ECODE_W, 6, width of the exception code field.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- ms_valid  input  1  MEM stage presents an instruction
- ws_allowin  output  1  WB can accept this cycle
- mem_pc  input  32  instruction PC
- mem_rf_we  input  1  instruction writes rd
- mem_rd  input  5  destination register
- mem_alu_result  input  32  ALU/address result
- mem_res_from_dram  input  1  result is load data
- mem_dram_rdata  input  32  raw data-SRAM word
- mem_rdram_num  input  2  load size: 0 byte, 1 half, 2 word, 3 reserved (treated as word)
- mem_rdram_need_signed_extend  input  1  1 = sign-extend, 0 = zero-extend
- mem_res_from_csr  input  1  result is CSR read data
- mem_csr_rdata  input  32  CSR read value
- mem_ex  input  1  instruction carries an exception
- mem_ecode  input  ECODE_W  exception code
- mem_is_ertn  input  1  instruction is ERTN
- rf_we  output  1  register-file write enable
- rf_waddr  output  5  register-file write address
- rf_wdata  output  32  register-file write data
- wb_ex  output  1  one-cycle exception commit pulse
- wb_ertn  output  1  one-cycle ERTN commit pulse
- wb_ecode  output  ECODE_W  ecode valid with wb_ex
- wb_ex_pc  output  32  PC of the excepting instruction, valid with wb_ex
- flush_busy  output  1  FSM in FLUSH
- retire_cnt  output  32  count of normally retired instructions

Behaviour:
- Reset (rst low, async): ws_valid=0, state=RUN, flush counter=0, all latched fields and retire_cnt=0.
- Outputs under reset: rf_we=0, wb_ex=0, wb_ertn=0, flush_busy=0, ws_allowin=1; every other output 0.
- ws_allowin=1 always: the block never stalls; it holds at most one instruction, one cycle.
- Capture: on each edge in RUN, ws_valid<=ms_valid and fields <=mem_*.
- In FLUSH, ws_valid<=0 and the MEM input is discarded, not latched.
- Load data: byte offset = mem_alu_result[1:0], latched with the fields.
  - Byte: select rdata[8*off+7:8*off].
  - Half: select rdata[16*off[1]+15:16*off[1]]; off[0] is ignored because misaligned loads already carry ALE.
  - Word: the whole word.
  - Then sign- or zero-extend to 32 bits.
- rf_wdata priority: res_from_csr > res_from_dram > alu_result. Combinational from the latch; 0-cycle latency from the latch.
- rf_we = ws_valid & rf_we_l & ~ex_l & ~ertn_l & (rd_l != 0). rf_waddr = rd_l.
- wb_ex = ws_valid & ex_l. wb_ertn = ws_valid & ertn_l & ~ex_l. If both are set, the exception wins.
- FSM RUN→FLUSH: on wb_ex or wb_ertn. Load flush counter with FLUSH_CYCLES.
- FSM FLUSH: decrement the counter each cycle; return to RUN when it reaches 1. A new exception cannot occur in FLUSH because ws_valid=0.
- retire_cnt: +1 on ws_valid & ~ex_l & ~ertn_l. ERTN does not count. Wraps 0xFFFFFFFF→0.
- Reset asserted mid-FLUSH: return immediately to RUN with the counter cleared.

Optional Feature:
- Macro WB_DEBUG_TRACE_EN, when defined, adds outputs debug_wb_pc[31:0], debug_wb_rf_we[3:0], debug_wb_rf_wnum[4:0] and debug_wb_rf_wdata[31:0].
  - debug_wb_pc = pc_l.
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_rf_wnum = rf_waddr.
  - debug_wb_rf_wdata = rf_wdata.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - ECODE constants (ADEF, ALE, SYS, BRK, INE, INT).
  - Load-size encodings LD_B=0, LD_H=1, LD_W=2.
  - FSM state typedef {RUN, FLUSH}.
- One natural sub-module: load_align_ext (combinational byte/half select and extension), reusable by the MEM stage.

Test Plan:
- Reset release, then ms_valid=1, ALU add, rd=5, result 0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x00001234, retire_cnt=1.
- ld.b signed, rdata=0x80FF7F01, addr[1:0]=3 → rf_wdata=0xFFFFFF80. Same with zero-extend → 0x00000080. ld.hu, addr[1:0]=2 → 0x000080FF.
- rd=0 with mem_rf_we=1 → rf_we=0, retire_cnt still increments.
- Exception case:
  - Stimulus: mem_ex=1, ecode=0x0B, pc=0x1C000100, followed by 3 back-to-back valid instructions.
  - Expected at commit: wb_ex pulse exactly one cycle with wb_ecode=0x0B, wb_ex_pc=0x1C000100, rf_we=0.
  - Expected afterwards: the next 2 instructions are dropped (flush_busy=1 for 2 cycles) and the 3rd commits.
- ERTN with mem_ex=0 → wb_ertn pulse one cycle, retire_cnt unchanged. mem_ex=1 with is_ertn=1 → only wb_ex pulses.
- Preload retire_cnt at 0xFFFFFFFF via 2^32 retires, or force in sim; retire → 0. Assert rst mid-FLUSH → flush_busy=0 immediately and the next instruction is accepted.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, load-size encodings and the WB flush FSM states.
package cpu_pkg;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wb_state_e;

    // MEM/WB latch contents (the exception code is kept apart because its width is a parameter).
    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic        res_from_dram;
        logic [31:0] dram_rdata;
        logic [1:0]  rdram_num;
        logic        sign_ext;
        logic        res_from_csr;
        logic [31:0] csr_rdata;
        logic        ex;
        logic        ertn;
    } wb_latch_t;

endpackage

// File: rtl/load_align_ext.sv
// Combinational load-data extraction: selects byte/half/word from the raw SRAM word and extends it.
module load_align_ext
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        // offset[0] is ignored for halves: misaligned loads arrive already tagged ALE.
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            LD_B:    data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            LD_H:    data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_commit_stage.sv
// WB/commit stage: MEM/WB latch, result select, register-file write, exception/ERTN commit and flush FSM.
// Define WB_DEBUG_TRACE_EN to add the debug_wb_* trace outputs.
module wb_commit_stage
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int ECODE_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ms_valid,
    output logic               ws_allowin,
    input  logic [31:0]        mem_pc,
    input  logic               mem_rf_we,
    input  logic [4:0]         mem_rd,
    input  logic [31:0]        mem_alu_result,
    input  logic               mem_res_from_dram,
    input  logic [31:0]        mem_dram_rdata,
    input  logic [1:0]         mem_rdram_num,
    input  logic               mem_rdram_need_signed_extend,
    input  logic               mem_res_from_csr,
    input  logic [31:0]        mem_csr_rdata,
    input  logic               mem_ex,
    input  logic [ECODE_W-1:0] mem_ecode,
    input  logic               mem_is_ertn,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [31:0]        rf_wdata,
    output logic               wb_ex,
    output logic               wb_ertn,
    output logic [ECODE_W-1:0] wb_ecode,
    output logic [31:0]        wb_ex_pc,
    output logic               flush_busy,
    output logic [31:0]        retire_cnt
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0]        debug_wb_pc,
    output logic [3:0]         debug_wb_rf_we,
    output logic [4:0]         debug_wb_rf_wnum,
    output logic [31:0]        debug_wb_rf_wdata
`endif
);

    wb_state_e          state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               valid_q, valid_d;
    wb_latch_t          lat_q, lat_d;
    logic [ECODE_W-1:0] ecode_q, ecode_d;
    logic [31:0]        retire_q, retire_d;
    logic [31:0]        load_data;
    logic               accept;

    // Handshake: MEM offers with ms_valid; WB never stalls (ws_allowin is constant 1), so a
    // transfer happens on every edge where ms_valid is high and WB is not flushing.
    assign ws_allowin = 1'b1;

    load_align_ext u_load_align_ext (
        .rdata    (lat_q.dram_rdata),
        .offset   (lat_q.alu_result[1:0]),
        .size     (lat_q.rdram_num),
        .sign_ext (lat_q.sign_ext),
        .data     (load_data)
    );

    always_comb begin
        rf_we      = valid_q & lat_q.rf_we & ~lat_q.ex & ~lat_q.ertn & (lat_q.rd != 5'd0);
        rf_waddr   = lat_q.rd;
        rf_wdata   = lat_q.res_from_csr  ? lat_q.csr_rdata :
                     lat_q.res_from_dram ? load_data       : lat_q.alu_result;
        wb_ex      = valid_q & lat_q.ex;
        wb_ertn    = valid_q & lat_q.ertn & ~lat_q.ex;
        wb_ecode   = ecode_q;
        wb_ex_pc   = lat_q.pc;
        flush_busy = (state_q == FLUSH);
        retire_cnt = retire_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (wb_ex || wb_ertn) begin
                    state_d = FLUSH;
                    cnt_d   = 4'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase

        // The committing edge already counts as flushed, so exactly FLUSH_CYCLES
        // younger instructions are dropped and the next one lands as FLUSH ends.
        accept  = (state_d == RUN);
        valid_d = accept & ms_valid;
        lat_d   = lat_q;
        ecode_d = ecode_q;
        if (accept) begin
            lat_d.pc            = mem_pc;
            lat_d.rf_we         = mem_rf_we;
            lat_d.rd            = mem_rd;
            lat_d.alu_result    = mem_alu_result;
            lat_d.res_from_dram = mem_res_from_dram;
            lat_d.dram_rdata    = mem_dram_rdata;
            lat_d.rdram_num     = mem_rdram_num;
            lat_d.sign_ext      = mem_rdram_need_signed_extend;
            lat_d.res_from_csr  = mem_res_from_csr;
            lat_d.csr_rdata     = mem_csr_rdata;
            lat_d.ex            = mem_ex;
            lat_d.ertn          = mem_is_ertn;
            ecode_d             = mem_ecode;
        end

        retire_d = retire_q + 32'(valid_q & ~lat_q.ex & ~lat_q.ertn);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            cnt_q    <= 4'd0;
            valid_q  <= 1'b0;
            lat_q    <= '0;
            ecode_q  <= '0;
            retire_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            lat_q    <= lat_d;
            ecode_q  <= ecode_d;
            retire_q <= retire_d;
        end
    end

`ifdef WB_DEBUG_TRACE_EN
    always_comb begin
        debug_wb_pc       = lat_q.pc;
        debug_wb_rf_we    = {4{rf_we}};
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;
    end
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed self-checking bench for wb_commit_stage: results, load extension, commit pulses, flush, wrap, reset.
module tb_wb_commit_stage;

    logic        clk;
    logic        rst;
    logic        ms_valid;
    logic        ws_allowin;
    logic [31:0] mem_pc;
    logic        mem_rf_we;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic        mem_res_from_dram;
    logic [31:0] mem_dram_rdata;
    logic [1:0]  mem_rdram_num;
    logic        mem_rdram_need_signed_extend;
    logic        mem_res_from_csr;
    logic [31:0] mem_csr_rdata;
    logic        mem_ex;
    logic [5:0]  mem_ecode;
    logic        mem_is_ertn;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_ex;
    logic        wb_ertn;
    logic [5:0]  wb_ecode;
    logic [31:0] wb_ex_pc;
    logic        flush_busy;
    logic [31:0] retire_cnt;
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
`endif

    int          checks;
    int          errors;
    logic [31:0] exp_retire;

    wb_commit_stage #(.FLUSH_CYCLES(2), .ECODE_W(6)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .ms_valid                     (ms_valid),
        .ws_allowin                   (ws_allowin),
        .mem_pc                       (mem_pc),
        .mem_rf_we                    (mem_rf_we),
        .mem_rd                       (mem_rd),
        .mem_alu_result               (mem_alu_result),
        .mem_res_from_dram            (mem_res_from_dram),
        .mem_dram_rdata               (mem_dram_rdata),
        .mem_rdram_num                (mem_rdram_num),
        .mem_rdram_need_signed_extend (mem_rdram_need_signed_extend),
        .mem_res_from_csr             (mem_res_from_csr),
        .mem_csr_rdata                (mem_csr_rdata),
        .mem_ex                       (mem_ex),
        .mem_ecode                    (mem_ecode),
        .mem_is_ertn                  (mem_is_ertn),
        .rf_we                        (rf_we),
        .rf_waddr                     (rf_waddr),
        .rf_wdata                     (rf_wdata),
        .wb_ex                        (wb_ex),
        .wb_ertn                      (wb_ertn),
        .wb_ecode                     (wb_ecode),
        .wb_ex_pc                     (wb_ex_pc),
        .flush_busy                   (flush_busy),
        .retire_cnt                   (retire_cnt)
`ifdef WB_DEBUG_TRACE_EN
        ,
        .debug_wb_pc                  (debug_wb_pc),
        .debug_wb_rf_we               (debug_wb_rf_we),
        .debug_wb_rf_wnum             (debug_wb_rf_wnum),
        .debug_wb_rf_wdata            (debug_wb_rf_wdata)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic clear_in();
        ms_valid                     = 1'b0;
        mem_pc                       = 32'd0;
        mem_rf_we                    = 1'b0;
        mem_rd                       = 5'd0;
        mem_alu_result               = 32'd0;
        mem_res_from_dram            = 1'b0;
        mem_dram_rdata               = 32'd0;
        mem_rdram_num                = 2'd0;
        mem_rdram_need_signed_extend = 1'b0;
        mem_res_from_csr             = 1'b0;
        mem_csr_rdata                = 32'd0;
        mem_ex                       = 1'b0;
        mem_ecode                    = 6'd0;
        mem_is_ertn                  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clear_in();
        step();
    endtask

    task automatic send_alu(input logic [4:0] rd, input logic [31:0] res);
        clear_in();
        ms_valid       = 1'b1;
        mem_pc         = 32'h1C00_0000 + {27'd0, rd};
        mem_rf_we      = 1'b1;
        mem_rd         = rd;
        mem_alu_result = res;
        step();
    endtask

    task automatic send_load(input logic [1:0] off, input logic [1:0] num, input logic sgn);
        clear_in();
        ms_valid                     = 1'b1;
        mem_rf_we                    = 1'b1;
        mem_rd                       = 5'd4;
        mem_alu_result               = {30'h0400_0000, off};
        mem_res_from_dram            = 1'b1;
        mem_dram_rdata               = 32'h80FF_7F01;
        mem_rdram_num                = num;
        mem_rdram_need_signed_extend = sgn;
        step();
    endtask

    task automatic send_exc(input logic ex, input logic ertn, input logic [5:0] ecode, input logic [31:0] pc);
        clear_in();
        ms_valid    = 1'b1;
        mem_pc      = pc;
        mem_rf_we   = 1'b1;
        mem_rd      = 5'd7;
        mem_ex      = ex;
        mem_ecode   = ecode;
        mem_is_ertn = ertn;
        step();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_retire = 32'd0;
        rst        = 1'b0;
        clear_in();
        step();
        step();

        chk("reset_allowin", 32'(ws_allowin), 32'd1);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_wb_ex", 32'(wb_ex), 32'd0);
        chk("reset_wb_ertn", 32'(wb_ertn), 32'd0);
        chk("reset_flush_busy", 32'(flush_busy), 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);
        chk("reset_retire", retire_cnt, 32'd0);
        rst = 1'b1;

        // Plain ALU result
        send_alu(5'd5, 32'h0000_1234);
        exp_retire++;
        chk("alu_rf_we", 32'(rf_we), 32'd1);
        chk("alu_waddr", 32'(rf_waddr), 32'd5);
        chk("alu_wdata", rf_wdata, 32'h0000_1234);
`ifdef WB_DEBUG_TRACE_EN
        chk("dbg_pc", debug_wb_pc, 32'h1C00_0005);
        chk("dbg_we", 32'(debug_wb_rf_we), 32'hF);
        chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'd5);
        chk("dbg_wdata", debug_wb_rf_wdata, 32'h0000_1234);
`endif
        idle();
        chk("alu_retire", retire_cnt, exp_retire);
        chk("idle_rf_we", 32'(rf_we), 32'd0);

        // Load extraction on rdata 0x80FF7F01
        send_load(2'd3, 2'd0, 1'b1); exp_retire++;
        chk("ld_b_off3", rf_wdata, 32'hFFFF_FF80);
        send_load(2'd3, 2'd0, 1'b0); exp_retire++;
        chk("ld_bu_off3", rf_wdata, 32'h0000_0080);
        send_load(2'd1, 2'd0, 1'b1); exp_retire++;
        chk("ld_b_off1", rf_wdata, 32'h0000_007F);
        send_load(2'd2, 2'd1, 1'b0); exp_retire++;
        chk("ld_hu_off2", rf_wdata, 32'h0000_80FF);
        send_load(2'd2, 2'd1, 1'b1); exp_retire++;
        chk("ld_h_off2", rf_wdata, 32'hFFFF_80FF);
        send_load(2'd0, 2'd1, 1'b1); exp_retire++;
        chk("ld_h_off0", rf_wdata, 32'h0000_7F01);
        send_load(2'd0, 2'd2, 1'b1); exp_retire++;
        chk("ld_w", rf_wdata, 32'h80FF_7F01);
        send_load(2'd0, 2'd3, 1'b0); exp_retire++;
        chk("ld_rsvd_as_w", rf_wdata, 32'h80FF_7F01);

        // CSR result beats load data
        clear_in();
        ms_valid          = 1'b1;
        mem_rf_we         = 1'b1;
        mem_rd            = 5'd6;
        mem_res_from_dram = 1'b1;
        mem_dram_rdata    = 32'h1111_1111;
        mem_res_from_csr  = 1'b1;
        mem_csr_rdata     = 32'hCAFE_0001;
        step();
        exp_retire++;
        chk("csr_priority", rf_wdata, 32'hCAFE_0001);

        // rd = 0 never writes but still retires
        send_alu(5'd0, 32'hDEAD_BEEF);
        exp_retire++;
        chk("rd0_rf_we", 32'(rf_we), 32'd0);
        idle();
        chk("rd0_retire", retire_cnt, exp_retire);

        // Exception then three back-to-back instructions
        send_exc(1'b1, 1'b0, 6'h0B, 32'h1C00_0100);
        chk("ex_pulse", 32'(wb_ex), 32'd1);
        chk("ex_ecode", 32'(wb_ecode), 32'h0B);
        chk("ex_pc", wb_ex_pc, 32'h1C00_0100);
        chk("ex_rf_we", 32'(rf_we), 32'd0);
        chk("ex_ertn", 32'(wb_ertn), 32'd0);
        send_alu(5'd1, 32'h11);
        chk("fl1_wb_ex", 32'(wb_ex), 32'd0);
        chk("fl1_busy", 32'(flush_busy), 32'd1);
        chk("fl1_rf_we", 32'(rf_we), 32'd0);
        send_alu(5'd2, 32'h22);
        chk("fl2_busy", 32'(flush_busy), 32'd1);
        chk("fl2_rf_we", 32'(rf_we), 32'd0);
        send_alu(5'd3, 32'h33);
        exp_retire++;
        chk("fl3_busy", 32'(flush_busy), 32'd0);
        chk("fl3_rf_we", 32'(rf_we), 32'd1);
        chk("fl3_waddr", 32'(rf_waddr), 32'd3);
        chk("fl3_wdata", rf_wdata, 32'h33);
        idle();
        chk("ex_retire", retire_cnt, exp_retire);

        // ERTN alone
        send_exc(1'b0, 1'b1, 6'h00, 32'h1C00_0200);
        chk("ertn_pulse", 32'(wb_ertn), 32'd1);
        chk("ertn_no_ex", 32'(wb_ex), 32'd0);
        chk("ertn_rf_we", 32'(rf_we), 32'd0);
        idle();
        chk("ertn_one_cycle", 32'(wb_ertn), 32'd0);
        chk("ertn_busy", 32'(flush_busy), 32'd1);
        idle();
        idle();
        chk("ertn_retire", retire_cnt, exp_retire);

        // Exception and ERTN together: exception wins
        send_exc(1'b1, 1'b1, 6'h0C, 32'h1C00_0300);
        chk("both_ex", 32'(wb_ex), 32'd1);
        chk("both_ertn", 32'(wb_ertn), 32'd0);
        chk("both_ecode", 32'(wb_ecode), 32'h0C);
        idle();
        idle();
        idle();
        chk("both_retire", retire_cnt, exp_retire);

        // retire_cnt wrap
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        exp_retire = 32'hFFFF_FFFF;
        chk("wrap_preload", retire_cnt, exp_retire);
        send_alu(5'd8, 32'h88);
        exp_retire++;
        idle();
        chk("wrap_zero", retire_cnt, 32'd0);

        // Reset in the middle of FLUSH
        send_exc(1'b1, 1'b0, 6'h09, 32'h1C00_0400);
        chk("rst_ex_pulse", 32'(wb_ex), 32'd1);
        send_alu(5'd1, 32'h11);
        chk("rst_pre_busy", 32'(flush_busy), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_busy_clear", 32'(flush_busy), 32'd0);
        chk("rst_retire_clear", retire_cnt, 32'd0);
        chk("rst_wb_ex", 32'(wb_ex), 32'd0);
        #1;
        rst = 1'b1;
        send_alu(5'd9, 32'h99);
        chk("rst_accept_we", 32'(rf_we), 32'd1);
        chk("rst_accept_data", rf_wdata, 32'h99);
        chk("rst_accept_busy", 32'(flush_busy), 32'd0);
        idle();
        chk("rst_accept_retire", retire_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
